stopwatch_counter: RTL and testbench

//  MM:SS stopwatch core; sits directly downstream of the clock divider.

---
 rtl/stopwatch_pkg.sv | 14 +
 rtl/stopwatch_if.sv | 27 ++
 rtl/bcd2_counter.sv | 54 +++++
 rtl/stopwatch_counter.sv | 95 +++++++++
 tb/tb_stopwatch_counter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared constants and FSM encoding for the stopwatch core
// and the downstream seven-segment display mux.
package stopwatch_pkg;

    localparam int BCD_W   = 4;
    localparam int SEC_MAX = 59;

    // ST_RUN is encoded as 1 so the state bit doubles as the running flag.
    typedef enum logic {
        ST_PAUSED = 1'b0,
        ST_RUN    = 1'b1
    } sw_state_t;

endpackage

// File: rtl/stopwatch_if.sv
// stopwatch_if: groups the stopwatch control inputs and BCD/status outputs.
//   master: drives clk_1hz, clk_2hz, pause, adj, sel; reads digits/running
//   slave : the stopwatch core (reads controls, drives digits/running)
interface stopwatch_if;
    import stopwatch_pkg::*;

    logic             clk_1hz;
    logic             clk_2hz;
    logic             pause;
    logic             adj;
    logic             sel;
    logic [BCD_W-1:0] min_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
    logic             running;

    modport master (
        output clk_1hz, clk_2hz, pause, adj, sel,
        input  min_tens, min_ones, sec_tens, sec_ones, running
    );

    modport slave (
        input  clk_1hz, clk_2hz, pause, adj, sel,
        output min_tens, min_ones, sec_tens, sec_ones, running
    );
endinterface

// File: rtl/bcd2_counter.sv
// bcd2_counter: two-digit BCD counter 00..MAX with wrap back to 00.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset, clears both digits
//   i_inc  : increment by one this cycle
//   o_tens : registered tens digit
//   o_ones : registered ones digit
//   o_wrap : combinational, high when i_inc arrives while at MAX
module bcd2_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [BCD_W-1:0] o_tens,
    output logic [BCD_W-1:0] o_ones,
    output logic             o_wrap
);

    localparam logic [BCD_W-1:0] MAX_T = BCD_W'(MAX / 10);
    localparam logic [BCD_W-1:0] MAX_O = BCD_W'(MAX % 10);
    localparam logic [BCD_W-1:0] NINE  = BCD_W'(9);
    localparam logic [BCD_W-1:0] ONE   = BCD_W'(1);

    logic [BCD_W-1:0] r_tens;
    logic [BCD_W-1:0] r_ones;
    logic             w_at_max;

    // Range check on the full two-digit value, not per digit.
    assign w_at_max = (r_tens == MAX_T) && (r_ones == MAX_O);
    assign o_wrap   = i_inc && w_at_max;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tens <= '0;
            r_ones <= '0;
        end else if (i_inc) begin
            if (w_at_max) begin
                r_tens <= '0;
                r_ones <= '0;
            end else if (r_ones == NINE) begin
                r_ones <= '0;
                r_tens <= r_tens + ONE;
            end else begin
                r_ones <= r_ones + ONE;
            end
        end
    end

    assign o_tens = r_tens;
    assign o_ones = r_ones;

endmodule

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS stopwatch core.
//   i_clk : system clock, the only clock
//   i_rst : synchronous active-high reset (digits 00:00, state RUN)
//   bus   : stopwatch_if.slave
//           clk_1hz/clk_2hz level inputs edge-detected into 1-cycle ticks,
//           pause pulse toggles RUN/PAUSED, adj/sel select adjust mode and
//           target field; outputs four registered BCD digits and running.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int MIN_MAX = 59
) (
    input  logic        i_clk,
    input  logic        i_rst,
    stopwatch_if.slave  bus
);

    logic      r_prev_1;
    logic      r_prev_2;
    sw_state_t r_state;
    sw_state_t w_state_nxt;

    logic w_tick_1;
    logic w_tick_2;
    logic w_sec_inc;
    logic w_min_inc;
    logic w_sec_wrap;
    logic w_min_wrap;

    // History regs load the live level on reset so a level already high at
    // release is not seen as a rising edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev_1 <= bus.clk_1hz;
            r_prev_2 <= bus.clk_2hz;
        end else begin
            r_prev_1 <= bus.clk_1hz;
            r_prev_2 <= bus.clk_2hz;
        end
    end

    assign w_tick_1 = bus.clk_1hz & ~r_prev_1;
    assign w_tick_2 = bus.clk_2hz & ~r_prev_2;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_RUN;
        else       r_state <= w_state_nxt;
    end

    // pause toggles regardless of adj.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.pause) begin
            w_state_nxt = (r_state == ST_RUN) ? ST_PAUSED : ST_RUN;
        end
    end

    // Count mode: tick_1 while running, seconds carry into minutes.
    // Adjust mode: tick_2 bumps only the selected field, never carries.
    // Increment uses the current state, so a tick coinciding with a pause
    // pulse in RUN still counts.
    always_comb begin
        w_sec_inc = 1'b0;
        w_min_inc = 1'b0;
        if (bus.adj) begin
            w_sec_inc = w_tick_2 &  bus.sel;
            w_min_inc = w_tick_2 & ~bus.sel;
        end else begin
            w_sec_inc = w_tick_1 && (r_state == ST_RUN);
            w_min_inc = w_sec_wrap;
        end
    end

    bcd2_counter #(.MAX(SEC_MAX)) u_sec (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_inc  (w_sec_inc),
        .o_tens (bus.sec_tens),
        .o_ones (bus.sec_ones),
        .o_wrap (w_sec_wrap)
    );

    // Minute wrap is silent: no flag leaves the block.
    bcd2_counter #(.MAX(MIN_MAX)) u_min (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_inc  (w_min_inc),
        .o_tens (bus.min_tens),
        .o_ones (bus.min_ones),
        .o_wrap (w_min_wrap)
    );

    assign bus.running = (r_state == ST_RUN);

endmodule

// File: tb/tb_stopwatch_counter.sv
module tb_stopwatch_counter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic c1 = 1'b0, c2 = 1'b0, pause = 1'b0, adj = 1'b0, sel = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stopwatch_if u_if59 ();
    stopwatch_if u_if99 ();

    assign u_if59.clk_1hz = c1;
    assign u_if59.clk_2hz = c2;
    assign u_if59.pause   = pause;
    assign u_if59.adj     = adj;
    assign u_if59.sel     = sel;
    assign u_if99.clk_1hz = c1;
    assign u_if99.clk_2hz = c2;
    assign u_if99.pause   = pause;
    assign u_if99.adj     = adj;
    assign u_if99.sel     = sel;

    stopwatch_counter #(.MIN_MAX(59)) u_dut59 (.i_clk(clk), .i_rst(rst), .bus(u_if59));
    stopwatch_counter #(.MIN_MAX(99)) u_dut99 (.i_clk(clk), .i_rst(rst), .bus(u_if99));

    // Reference model: minutes/seconds as plain integers.
    int mm_max [2] = '{59, 99};
    int m_min  [2];
    int m_sec  [2];
    bit m_run  [2];
    bit m_p1, m_p2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] st59();
        return {u_if59.running, u_if59.min_tens, u_if59.min_ones, u_if59.sec_tens, u_if59.sec_ones};
    endfunction

    function automatic logic [16:0] st99();
        return {u_if99.running, u_if99.min_tens, u_if99.min_ones, u_if99.sec_tens, u_if99.sec_ones};
    endfunction

    function automatic logic [16:0] model_st(input int k);
        logic [16:0] v;
        v = {m_run[k], 4'(m_min[k] / 10), 4'(m_min[k] % 10), 4'(m_sec[k] / 10), 4'(m_sec[k] % 10)};
        return v;
    endfunction

    task automatic model_step();
        bit t1, t2;
        t1 = c1 && !m_p1;
        t2 = c2 && !m_p2;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_min[k] = 0; m_sec[k] = 0; m_run[k] = 1'b1;
            end else begin
                if (!adj) begin
                    if (m_run[k] && t1) begin
                        m_sec[k]++;
                        if (m_sec[k] == 60) begin
                            m_sec[k] = 0;
                            m_min[k] = (m_min[k] == mm_max[k]) ? 0 : m_min[k] + 1;
                        end
                    end
                end else if (t2) begin
                    if (sel) m_sec[k] = (m_sec[k] + 1) % 60;
                    else     m_min[k] = (m_min[k] + 1) % (mm_max[k] + 1);
                end
                if (pause) m_run[k] = !m_run[k];
            end
        end
        m_p1 = c1;
        m_p2 = c2;
    endtask

    // One clock: model advances on the same edge, outputs compared 1 ns later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("cyc59", 32'(st59()), 32'(model_st(0)));
        chk("cyc99", 32'(st99()), 32'(model_st(1)));
    endtask

    task automatic rise1();
        c1 = 1'b1; cycle(); cycle();
        c1 = 1'b0; cycle(); cycle();
    endtask

    task automatic rise2();
        c2 = 1'b1; cycle(); cycle();
        c2 = 1'b0; cycle(); cycle();
    endtask

    task automatic pulse_pause();
        pause = 1'b1; cycle();
        pause = 1'b0; cycle();
    endtask

    task automatic do_reset();
        adj = 1'b0; sel = 1'b0; pause = 1'b0;
        rst = 1'b1; cycle(); cycle();
        rst = 1'b0; cycle();
    endtask

    initial begin
        // 1: reset state, then 60 seconds -> 01:00
        do_reset();
        chk("rst59", 32'(st59()), 32'(17'h10000));
        chk("rst99", 32'(st99()), 32'(17'h10000));
        repeat (60) rise1();
        chk("t1_0100", 32'(st59()), 32'(17'h10100));

        // 2: minute wrap at MIN_MAX:59 for both parameterisations
        do_reset();
        adj = 1'b1; sel = 1'b0;
        repeat (99) rise2();
        sel = 1'b1;
        repeat (59) rise2();
        chk("t2_9959", 32'(st99()), 32'(17'h19959));
        adj = 1'b0;
        rise1();
        chk("t2_wrap99", 32'(st99()), 32'(17'h10000));
        chk("t2_no_wrap59", 32'(st59()), 32'(17'h14000));
        do_reset();
        adj = 1'b1; sel = 1'b0;
        repeat (59) rise2();
        sel = 1'b1;
        repeat (59) rise2();
        adj = 1'b0;
        rise1();
        chk("t2_wrap59", 32'(st59()), 32'(17'h10000));

        // 3: pause holds count
        do_reset();
        repeat (10) rise1();
        pulse_pause();
        repeat (5) rise1();
        chk("t3_paused", 32'(st59()), 32'(17'h00010));
        pulse_pause();
        rise1();
        chk("t3_resume", 32'(st59()), 32'(17'h10011));

        // 4: adjust seconds without carry, then minutes
        do_reset();
        adj = 1'b1; sel = 1'b0;
        repeat (2) rise2();
        sel = 1'b1;
        repeat (58) rise2();
        chk("t4_0258", 32'(st59()), 32'(17'h10258));
        repeat (3) rise2();
        repeat (4) rise1();
        chk("t4_0201", 32'(st59()), 32'(17'h10201));
        sel = 1'b0;
        rise2();
        chk("t4_0301", 32'(st59()), 32'(17'h10301));

        // 5: tick and pause in the same cycle
        do_reset();
        repeat (5) rise1();
        c1 = 1'b1; pause = 1'b1; cycle();
        pause = 1'b0; cycle();
        c1 = 1'b0; cycle(); cycle();
        chk("t5_0006", 32'(st59()), 32'(17'h00006));
        rise1();
        chk("t5_hold", 32'(st59()), 32'(17'h00006));

        // 6: reset released with clk_1hz held high
        do_reset();
        repeat (3) rise1();
        c1 = 1'b1; cycle();
        rst = 1'b1; cycle(); cycle();
        rst = 1'b0; cycle(); cycle(); cycle();
        chk("t6_rst", 32'(st59()), 32'(17'h10000));
        c1 = 1'b0; cycle();
        c1 = 1'b1; cycle(); cycle();
        chk("t6_first", 32'(st59()), 32'(17'h10001));
        c1 = 1'b0; cycle();

        // Random phase against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(5) == 0) c1 = ~c1;
            if ($urandom_range(4) == 0) c2 = ~c2;
            pause = ($urandom_range(11) == 0);
            if ($urandom_range(39) == 0) adj = ~adj;
            if ($urandom_range(19) == 0) sel = ~sel;
            rst = ($urandom_range(599) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
